usb_ep_out_pkt_writer: RTL and testbench
========================================

// Module: usb_ep_out_pkt_writer
// PURPOSE
//  Upstream fill stage of the endpoint BRAM FIFO for OUT/SETUP data. Takes the
//  depacketised byte stream from USB RX and writes it into the FIFO as one fill
//  transaction. At packet end it commits the transaction (CRC ok, no overflow)
//  or rolls it back, so corrupt or oversized packets never reach the endpoint.
// PARAMETERS
//  EP_ADDR_WID    9   FIFO address width; sizes pktLen
//  EP_DATA_WID    8   byte width, must match FIFO
//  MAX_PKT_BYTES  64  max payload bytes (used only with EP_MAX_PKT_CHECK_EN)
// PORTS
//  CLK               in   1              clock
//  rst_n             in   1              synchronous reset, active low
//  rxStart           in   1              pulse: new data packet begins
//  rxValid           in   1              rxData valid this cycle (no stall possible)
//  rxData            in   EP_DATA_WID    payload byte
//  rxEnd             in   1              pulse: packet ended (after or with last byte)
//  rxCrcOk           in   1              CRC16 result, qualified by rxEnd
//  full              in   1              FIFO full
//  dataValid         out  1              FIFO write strobe
//  dataIn            out  EP_DATA_WID    FIFO write data
//  fillTransDone     out  1              FIFO transaction end strobe
//  fillTransSuccess  out  1              commit(1) / rollback(0); valid with fillTransDone
//  pktDone           out  1              pulse, same cycle as fillTransDone
//  pktOk             out  1              = fillTransSuccess, held until next pktDone
//  pktLen            out  EP_ADDR_WID+1  bytes written in last packet, held until next pktDone
//  busy              out  1              state != IDLE
// BEHAVIOUR
//  States: IDLE, RECV, DROP, COMMIT. Reset -> IDLE.
//   All outputs 0 (pktLen = 0). Internal ovf/restart flags cleared.
//  IDLE:   rxStart -> RECV; count <= 0; ovf <= 0. rxValid/rxEnd ignored.
//  RECV:   dataValid = rxValid & !full (combinational); dataIn = rxData; count++ per write.
//          rxValid & full -> ovf <= 1; next state DROP.
//  DROP:   bytes discarded, no dataValid.
//  RECV/DROP on rxEnd -> COMMIT next cycle. A byte with rxEnd is written first.
//          success is latched as rxCrcOk & !ovf.
//  COMMIT: exactly one cycle. fillTransDone=1, fillTransSuccess=latched success,
//          pktDone=1. pktLen<=count, pktOk<=success. dataValid forced 0 (never
//          concurrent with the transaction strobe). Next: IDLE, or RECV if restart.
//  rxStart while RECV/DROP (lost rxEnd) -> COMMIT with success=0; restart<=1;
//          COMMIT then goes to RECV with count/ovf cleared.
//  rxValid during COMMIT: byte lost; sets ovf for the following packet.
//  Zero-length packet: rxStart then rxEnd -> COMMIT, success=rxCrcOk, pktLen=0.
//  count saturates at 2^EP_ADDR_WID and cannot exceed it, because full stops writes.
//  Reset mid-packet: no fillTransDone issued. FIFO must be reset in the same cycle.
//  Latency: rxValid -> dataValid 0 cycles; rxEnd -> fillTransDone 1 cycle.
// CONFIGURATION
//  EP_MAX_PKT_CHECK_EN defined:
//   - a RECV write with count == MAX_PKT_BYTES is suppressed; ovf <= 1; state -> DROP.
//   - packets longer than MAX_PKT_BYTES are rolled back.
//  EP_MAX_PKT_CHECK_EN not defined: only FIFO full limits length; MAX_PKT_BYTES unused.
// STRUCTURE
//  usb_ep_pkg:
//   - typedef enum logic [1:0] ep_wr_state_t {IDLE,RECV,DROP,COMMIT}
//   - USB_BYTE_WID = 8
//  Single module, no sub-module. Byte counter and state register are inline.
// TESTING
//  1. 8 bytes 0x01..0x08, rxEnd+rxCrcOk=1 -> 8 writes, COMMIT success=1, pktLen=8.
//  2. 4 bytes, rxEnd with rxCrcOk=0 -> 4 writes, fillTransSuccess=0, pktOk=0, pktLen=4.
//  3. full=1 after 3rd byte, 6 bytes sent, CRC ok -> 3 writes, DROP, success=0.
//  4. ZLP (rxStart, 2 idle, rxEnd, crc ok) -> 0 writes, success=1, pktLen=0.
//  5. rxStart mid-packet after 5 bytes -> failing COMMIT pktLen=5, new packet of
//     3 bytes commits with pktLen=3.
//  6. EP_MAX_PKT_CHECK_EN, MAX_PKT_BYTES=64, 65 bytes -> 64 writes, success=0;
//     rst_n low mid-packet -> all outputs 0, no fillTransDone.

Source files
------------

// File: rtl/usb_ep_pkg.sv
// Shared types for the USB endpoint FIFO fill path: write-FSM states and byte width.
package usb_ep_pkg;

    localparam int USB_BYTE_WID = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        DROP   = 2'd2,
        COMMIT = 2'd3
    } ep_wr_state_t;

endpackage

// File: rtl/usb_ep_out_pkt_writer.sv
// OUT/SETUP packet writer: streams RX bytes into the endpoint FIFO and commits or rolls back per packet.
// Optional length limit enabled with `define EP_MAX_PKT_CHECK_EN.
module usb_ep_out_pkt_writer
    import usb_ep_pkg::*;
#(
    parameter int EP_ADDR_WID   = 9,
    parameter int EP_DATA_WID   = USB_BYTE_WID,
    parameter int MAX_PKT_BYTES = 64
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   rxStart,
    input  logic                   rxValid,
    input  logic [EP_DATA_WID-1:0] rxData,
    input  logic                   rxEnd,
    input  logic                   rxCrcOk,
    input  logic                   full,
    output logic                   dataValid,
    output logic [EP_DATA_WID-1:0] dataIn,
    output logic                   fillTransDone,
    output logic                   fillTransSuccess,
    output logic                   pktDone,
    output logic                   pktOk,
    output logic [EP_ADDR_WID:0]   pktLen,
    output logic                   busy
);

    localparam int                 CNT_WID = EP_ADDR_WID + 1;
    localparam logic [CNT_WID-1:0] CNT_SAT = {1'b1, {EP_ADDR_WID{1'b0}}};

    ep_wr_state_t       state_q, state_d;
    logic [CNT_WID-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               restart_q, restart_d;
    logic               success_q, success_d;
    logic [CNT_WID-1:0] pkt_len_q, pkt_len_d;
    logic               pkt_ok_q, pkt_ok_d;

    logic               at_max;
    logic               wr_ok;
    logic               ovf_now;
    logic               data_valid;
    logic               trans_done;

`ifdef EP_MAX_PKT_CHECK_EN
    localparam logic [CNT_WID-1:0] CNT_MAX = CNT_WID'(MAX_PKT_BYTES);
    assign at_max = (count_q == CNT_MAX);
`else
    assign at_max = 1'b0;
`endif

    // A byte that cannot be stored (FIFO full or over the length limit) poisons the packet.
    assign wr_ok   = rxValid & ~full & ~at_max;
    assign ovf_now = rxValid & (full | at_max);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        restart_d  = restart_q;
        success_d  = success_q;
        pkt_len_d  = pkt_len_q;
        pkt_ok_d   = pkt_ok_q;
        data_valid = 1'b0;
        trans_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (rxStart) begin
                    state_d   = RECV;
                    count_d   = '0;
                    ovf_d     = 1'b0;
                    restart_d = 1'b0;
                end
            end

            RECV: begin
                data_valid = wr_ok;
                if (wr_ok && (count_q != CNT_SAT)) begin
                    count_d = count_q + 1'b1;
                end
                if (rxStart) begin
                    // Lost rxEnd: fail this packet and resume straight into the new one.
                    state_d   = COMMIT;
                    success_d = 1'b0;
                    restart_d = 1'b1;
                end else if (rxEnd) begin
                    state_d   = COMMIT;
                    ovf_d     = ovf_q | ovf_now;
                    success_d = rxCrcOk & ~ovf_q & ~ovf_now;
                end else if (ovf_now) begin
                    state_d = DROP;
                    ovf_d   = 1'b1;
                end
            end

            DROP: begin
                if (rxStart) begin
                    state_d   = COMMIT;
                    success_d = 1'b0;
                    restart_d = 1'b1;
                end else if (rxEnd) begin
                    state_d   = COMMIT;
                    success_d = rxCrcOk & ~ovf_q;
                end
            end

            COMMIT: begin
                trans_done = 1'b1;
                pkt_len_d  = count_q;
                pkt_ok_d   = success_q;
                count_d    = '0;
                // A byte arriving now has nowhere to go; mark the next packet as damaged.
                ovf_d      = rxValid;
                restart_d  = 1'b0;
                state_d    = restart_q ? RECV : IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            restart_q <= 1'b0;
            success_q <= 1'b0;
            pkt_len_q <= '0;
            pkt_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            restart_q <= restart_d;
            success_q <= success_d;
            pkt_len_q <= pkt_len_d;
            pkt_ok_q  <= pkt_ok_d;
        end
    end

    assign dataValid        = data_valid;
    assign dataIn           = data_valid ? rxData : '0;
    assign fillTransDone    = trans_done;
    assign fillTransSuccess = trans_done & success_q;
    assign pktDone          = trans_done;
    assign pktOk            = pkt_ok_q;
    assign pktLen           = pkt_len_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_usb_ep_out_pkt_writer.sv
// Directed bench for usb_ep_out_pkt_writer: table of single-packet vectors plus
// hand-written restart and mid-packet reset sequences.
module tb_usb_ep_out_pkt_writer;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          rxStart, rxValid, rxEnd, rxCrcOk, full;
    logic [DW-1:0] rxData;
    logic          dataValid, fillTransDone, fillTransSuccess, pktDone, pktOk, busy;
    logic [DW-1:0] dataIn;
    logic [AW:0]   pktLen;

    int tests = 0;
    int fails = 0;
    int write_cnt = 0;
    int done_cnt = 0;
    logic last_succ = 1'b0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        string name;
        int    nbytes;
        int    full_after;     // -1: never full; else full from this byte index on
        bit    crc;
        bit    end_with_last;
        int    gap;            // idle cycles before a separate rxEnd
        int    exp_writes;
        bit    exp_ok;
        int    exp_len;
    } vec_t;

    vec_t vecs[7];

    usb_ep_out_pkt_writer #(.EP_ADDR_WID(AW), .EP_DATA_WID(DW), .MAX_PKT_BYTES(64)) dut (
        .CLK(clk), .rst_n(rst_n), .rxStart(rxStart), .rxValid(rxValid), .rxData(rxData),
        .rxEnd(rxEnd), .rxCrcOk(rxCrcOk), .full(full), .dataValid(dataValid), .dataIn(dataIn),
        .fillTransDone(fillTransDone), .fillTransSuccess(fillTransSuccess), .pktDone(pktDone),
        .pktOk(pktOk), .pktLen(pktLen), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/transaction monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dataValid) begin
                write_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL write_unexpected: got data 0x%02h, expected no write", dataIn);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (dataIn !== e) begin
                        fails++;
                        $display("FAIL write_data: got 0x%02h expected 0x%02h", dataIn, e);
                    end
                end
            end
            if (fillTransDone) begin
                done_cnt++;
                last_succ = fillTransSuccess;
                tests++;
                if (!pktDone || dataValid) begin
                    fails++;
                    $display("FAIL commit_strobes: pktDone=%0b dataValid=%0b expected 1/0", pktDone, dataValid);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input bit st, input bit v, input logic [DW-1:0] d, input bit en,
                       input bit crc, input bit fl);
        rxStart = st; rxValid = v; rxData = d; rxEnd = en; rxCrcOk = crc; full = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dataValid"}, int'(dataValid), 0);
        check({tag, "_dataIn"}, int'(dataIn), 0);
        check({tag, "_fillTransDone"}, int'(fillTransDone), 0);
        check({tag, "_fillTransSuccess"}, int'(fillTransSuccess), 0);
        check({tag, "_pktDone"}, int'(pktDone), 0);
        check({tag, "_pktOk"}, int'(pktOk), 0);
        check({tag, "_pktLen"}, int'(pktLen), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic wait_done(input int d_target);
        for (int k = 0; k < 6 && done_cnt < d_target; k++) idle();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int w0;
        int d0;
        logic [DW-1:0] base;
        w0 = write_cnt;
        d0 = done_cnt;
        base = DW'(idx * 16 + 1);
        for (int i = 0; i < v.exp_writes; i++) exp_q.push_back(base + DW'(i));
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < v.nbytes; i++) begin
            cyc(1'b0, 1'b1, base + DW'(i), v.end_with_last && (i == v.nbytes - 1), v.crc,
                (v.full_after >= 0) && (i >= v.full_after));
        end
        if (!(v.end_with_last && v.nbytes > 0)) begin
            repeat (v.gap) idle();
            cyc(1'b0, 1'b0, 8'h00, 1'b1, v.crc, 1'b0);
        end
        wait_done(d0 + 1);
        check({v.name, "_done_cnt"}, done_cnt - d0, 1);
        check({v.name, "_success"}, int'(last_succ), int'(v.exp_ok));
        check({v.name, "_pktOk"}, int'(pktOk), int'(v.exp_ok));
        check({v.name, "_pktLen"}, int'(pktLen), v.exp_len);
        check({v.name, "_writes"}, write_cnt - w0, v.exp_writes);
        check({v.name, "_busy"}, int'(busy), 0);
        check({v.name, "_exp_left"}, exp_q.size(), 0);
        idle();
    endtask

    initial begin
        vecs[0] = '{"crc_ok_8", 8, -1, 1'b1, 1'b0, 0, 8, 1'b1, 8};
        vecs[1] = '{"crc_bad_4", 4, -1, 1'b0, 1'b1, 0, 4, 1'b0, 4};
        vecs[2] = '{"full_after3", 6, 3, 1'b1, 1'b0, 0, 3, 1'b0, 3};
        vecs[3] = '{"zlp", 0, -1, 1'b1, 1'b0, 2, 0, 1'b1, 0};
        vecs[4] = '{"end_with_last_8", 8, -1, 1'b1, 1'b1, 0, 8, 1'b1, 8};
        vecs[5] = '{"full_on_end_byte", 5, 4, 1'b1, 1'b1, 0, 4, 1'b0, 4};
`ifdef EP_MAX_PKT_CHECK_EN
        vecs[6] = '{"len65_limited", 65, -1, 1'b1, 1'b0, 0, 64, 1'b0, 64};
`else
        vecs[6] = '{"len65_unlimited", 65, -1, 1'b1, 1'b0, 0, 65, 1'b1, 65};
`endif

        rst_n = 1'b0;
        rxStart = 1'b0; rxValid = 1'b0; rxData = '0; rxEnd = 1'b0; rxCrcOk = 1'b0; full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // rxStart arrives mid-packet: failing commit, then the new packet runs on.
        begin
            int d0;
            d0 = done_cnt;
            for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + 8'(i));
            cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            idle();
            check("restart_done1", done_cnt - d0, 1);
            check("restart_success1", int'(last_succ), 0);
            check("restart_pktLen1", int'(pktLen), 5);
            check("restart_pktOk1", int'(pktOk), 0);
            check("restart_busy", int'(busy), 1);
            for (int i = 0; i < 3; i++) exp_q.push_back(8'hB0 + 8'(i));
            for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hB0 + 8'(i), i == 2, 1'b1, 1'b0);
            wait_done(d0 + 2);
            check("restart_done2", done_cnt - d0, 2);
            check("restart_success2", int'(last_succ), 1);
            check("restart_pktLen2", int'(pktLen), 3);
            check("restart_pktOk2", int'(pktOk), 1);
            check("restart_exp_left", exp_q.size(), 0);
            idle();
        end

        // Reset in the middle of a packet: no commit, everything back to zero.
        begin
            int d0;
            d0 = done_cnt;
            for (int i = 0; i < 3; i++) exp_q.push_back(8'hC0 + 8'(i));
            cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1, 1'b0);
            rst_n = 1'b0;
            idle();
            rxStart = 1'b1; rxValid = 1'b1; rxData = 8'h55; rxEnd = 1'b1; rxCrcOk = 1'b1;
            #1;
            check_all_zero("midreset");
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            idle();
            idle();
            idle();
            check("midreset_no_done", done_cnt - d0, 0);
            check("midreset_exp_left", exp_q.size(), 0);
            run_vec(vecs[0], 8);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
